// File: rtl/memory_arbiter_if.sv
// Bundles the requester handshakes, the memory data port and the status
// outputs of the arbiter; the arbiter takes the slave view, the environment the master view.
interface memory_arbiter_if #(
  parameter int DW         = 32,
  parameter int ADDR_WIDTH = 14
);
  logic                  cpu_request;
  logic                  cpu_write;
  logic [ADDR_WIDTH-1:0] cpu_address;
  logic [DW-1:0]         cpu_data_in;
  logic                  cpu_ack;
  logic [DW-1:0]         cpu_data_out;

  logic                  dma_request;
  logic                  dma_write;
  logic [ADDR_WIDTH-1:0] dma_address;
  logic [DW-1:0]         dma_data_in;
  logic                  dma_ack;
  logic [DW-1:0]         dma_data_out;

  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DW-1:0]         mem_input_data;
  logic                  mem_write_enable;
  logic [DW-1:0]         mem_output_data;

  logic                  busy;
  logic                  grant_dma;

  modport slave (
    input  cpu_request, cpu_write, cpu_address, cpu_data_in,
    input  dma_request, dma_write, dma_address, dma_data_in,
    input  mem_output_data,
    output cpu_ack, cpu_data_out, dma_ack, dma_data_out,
    output mem_address, mem_input_data, mem_write_enable,
    output busy, grant_dma
  );

  modport master (
    output cpu_request, cpu_write, cpu_address, cpu_data_in,
    output dma_request, dma_write, dma_address, dma_data_in,
    output mem_output_data,
    input  cpu_ack, cpu_data_out, dma_ack, dma_data_out,
    input  mem_address, mem_input_data, mem_write_enable,
    input  busy, grant_dma
  );
endinterface

// File: rtl/memory_arbiter.sv
// Two-port (CPU priority, DMA anti-starvation) arbiter for a single memory data port.
// IDLE -> ISSUE -> DONE per transaction; ack in the DONE cycle, one transaction per 3 cycles.
module memory_arbiter #(
  parameter int DW         = 32,
  parameter int ADDR_WIDTH = 14,
  parameter int MAX_WAIT   = 4
) (
  input logic              clock,
  input logic              reset,
  memory_arbiter_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic [1:0]            state_q, state_d;
  logic [3:0]            wait_q, wait_d;
  logic                  grant_q, grant_d;
  logic                  wr_q, wr_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DW-1:0]         wdata_q, wdata_d;
  logic [DW-1:0]         cpu_dout_q, cpu_dout_d;
  logic [DW-1:0]         dma_dout_q, dma_dout_d;
  logic                  dma_wins;
  logic                  done_rd;

  assign dma_wins = bus.dma_request && (!bus.cpu_request || (wait_q == WAIT_LIMIT));

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    grant_d    = grant_q;
    wr_d       = wr_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cpu_dout_d = cpu_dout_q;
    dma_dout_d = dma_dout_q;

    case (state_q)
      S_IDLE: begin
        we_d = 1'b0;
        if (bus.cpu_request || bus.dma_request) begin
          state_d = S_ISSUE;
          grant_d = dma_wins;
          if (dma_wins) begin
            addr_d  = bus.dma_address;
            wr_d    = bus.dma_write;
            we_d    = bus.dma_write;
            wdata_d = bus.dma_data_in;
            wait_d  = 4'd0;
          end else begin
            addr_d  = bus.cpu_address;
            wr_d    = bus.cpu_write;
            we_d    = bus.cpu_write;
            wdata_d = bus.cpu_data_in;
            if (bus.dma_request && (wait_q != WAIT_LIMIT)) begin
              wait_d = wait_q + 4'd1;
            end
          end
        end
      end
      S_ISSUE: begin
        // The write commits at this closing edge; address and data stay put.
        we_d    = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (!wr_q) begin
          if (grant_q) begin
            dma_dout_d = bus.mem_output_data;
          end else begin
            cpu_dout_d = bus.mem_output_data;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      wait_q     <= 4'd0;
      grant_q    <= 1'b0;
      wr_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cpu_dout_q <= '0;
      dma_dout_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      grant_q    <= grant_d;
      wr_q       <= wr_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cpu_dout_q <= cpu_dout_d;
      dma_dout_q <= dma_dout_d;
    end
  end

  // Memory read data only arrives after the ISSUE-closing edge, so the owner's
  // data_out passes it straight through during DONE and the register holds it afterwards.
  assign done_rd = (state_q == S_DONE) && !wr_q;

  assign bus.cpu_ack          = (state_q == S_DONE) && !grant_q;
  assign bus.dma_ack          = (state_q == S_DONE) &&  grant_q;
  assign bus.cpu_data_out     = (done_rd && !grant_q) ? bus.mem_output_data : cpu_dout_q;
  assign bus.dma_data_out     = (done_rd &&  grant_q) ? bus.mem_output_data : dma_dout_q;
  assign bus.mem_address      = addr_q;
  assign bus.mem_input_data   = wdata_q;
  assign bus.mem_write_enable = we_q;
  assign bus.busy             = (state_q != S_IDLE);
  assign bus.grant_dma        = (state_q != S_IDLE) && grant_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model with its own memory image.
module tb_memory_arbiter;

  localparam int DW       = 32;
  localparam int AW       = 14;
  localparam int MAX_WAIT = 4;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_err;

  logic [DW-1:0] mem [0:16383];

  memory_arbiter_if #(.DW(DW), .ADDR_WIDTH(AW)) bus ();

  memory_arbiter #(.DW(DW), .ADDR_WIDTH(AW), .MAX_WAIT(MAX_WAIT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Memory with registered read data and write at the sampling edge.
  always @(posedge clock) begin
    if (bus.mem_write_enable) mem[bus.mem_address] <= bus.mem_input_data;
    bus.mem_output_data <= mem[bus.mem_address];
  end

  task automatic apply_reset();
    @(negedge clock);
    reset           = 1'b1;
    #1 reset        = 1'b0;
    bus.cpu_request = 1'b0;
    bus.dma_request = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
  endtask

  // Runs one transaction on one port; lat = cycle index of the ack (-1 on timeout).
  task automatic run_txn(input bit is_dma, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output int lat, output logic [DW-1:0] rd,
                         output int we_cyc, output int busy_cyc, output int other_ack);
    lat = -1; rd = '0; we_cyc = 0; busy_cyc = 0; other_ack = 0;
    @(negedge clock);
    if (is_dma) begin
      bus.dma_request = 1'b1; bus.dma_write = wr; bus.dma_address = a; bus.dma_data_in = d;
    end else begin
      bus.cpu_request = 1'b1; bus.cpu_write = wr; bus.cpu_address = a; bus.cpu_data_in = d;
    end
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock); #1;
      busy_cyc += int'(bus.busy);
      we_cyc   += int'(bus.mem_write_enable);
      other_ack += int'(is_dma ? bus.cpu_ack : bus.dma_ack);
      if (is_dma ? bus.dma_ack : bus.cpu_ack) begin
        lat = i;
        rd  = is_dma ? bus.dma_data_out : bus.cpu_data_out;
        break;
      end
    end
    @(negedge clock);
    bus.cpu_request = 1'b0;
    bus.dma_request = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.grant_dma !== 1'b0) begin n_err++; $display("FAIL reset_grant: got %b want 0", bus.grant_dma); end
    n_cmp++; if ({bus.cpu_ack, bus.dma_ack} !== 2'b00) begin n_err++; $display("FAIL reset_acks: got %b want 00", {bus.cpu_ack, bus.dma_ack}); end
    n_cmp++; if (bus.mem_write_enable !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b want 0", bus.mem_write_enable); end
    n_cmp++; if ({bus.mem_address, bus.mem_input_data} !== '0) begin n_err++; $display("FAIL reset_mem_bus: got %h/%h want 0", bus.mem_address, bus.mem_input_data); end
    n_cmp++; if ({bus.cpu_data_out, bus.dma_data_out} !== '0) begin n_err++; $display("FAIL reset_dout: got %h/%h want 0", bus.cpu_data_out, bus.dma_data_out); end
  endtask

  task automatic test_cpu_read();
    int lat, wec, bc, oa; logic [DW-1:0] rd;
    mem[14'h0010] = 32'hDEADBEEF;
    run_txn(1'b0, 1'b0, 14'h0010, '0, lat, rd, wec, bc, oa);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL cpu_read_latency: got %0d want 2", lat); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL cpu_read_data: got %h want deadbeef", rd); end
    n_cmp++; if (oa !== 0) begin n_err++; $display("FAIL cpu_read_dma_ack: got %0d want 0", oa); end
    n_cmp++; if (bc !== 2) begin n_err++; $display("FAIL cpu_read_busy_cycles: got %0d want 2", bc); end
    n_cmp++; if (wec !== 0) begin n_err++; $display("FAIL cpu_read_we: got %0d want 0", wec); end
  endtask

  task automatic test_cpu_write_read();
    int lat, wec, bc, oa; logic [DW-1:0] rd;
    run_txn(1'b0, 1'b1, 14'h0020, 32'h12345678, lat, rd, wec, bc, oa);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL cpu_write_latency: got %0d want 2", lat); end
    n_cmp++; if (wec !== 1) begin n_err++; $display("FAIL cpu_write_we_cycles: got %0d want 1", wec); end
    n_cmp++; if (mem[14'h0020] !== 32'h12345678) begin n_err++; $display("FAIL cpu_write_mem: got %h want 12345678", mem[14'h0020]); end
    run_txn(1'b0, 1'b0, 14'h0020, '0, lat, rd, wec, bc, oa);
    n_cmp++; if (rd !== 32'h12345678) begin n_err++; $display("FAIL cpu_readback: got %h want 12345678", rd); end
  endtask

  task automatic test_dma_write_read();
    int lat, wec, bc, oa; logic [DW-1:0] rd;
    run_txn(1'b1, 1'b1, 14'h3FFF, 32'hFFFFFFFF, lat, rd, wec, bc, oa);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL dma_write_latency: got %0d want 2", lat); end
    n_cmp++; if (mem[14'h3FFF] !== 32'hFFFFFFFF) begin n_err++; $display("FAIL dma_write_mem: got %h want ffffffff", mem[14'h3FFF]); end
    run_txn(1'b1, 1'b0, 14'h3FFF, '0, lat, rd, wec, bc, oa);
    n_cmp++; if (rd !== 32'hFFFFFFFF) begin n_err++; $display("FAIL dma_readback: got %h want ffffffff", rd); end
    n_cmp++; if (oa !== 0) begin n_err++; $display("FAIL dma_cpu_ack: got %0d want 0", oa); end
    n_cmp++; if (bus.cpu_data_out !== 32'h12345678) begin n_err++; $display("FAIL dma_cpu_dout_kept: got %h want 12345678", bus.cpu_data_out); end
  endtask

  task automatic test_arbitration();
    int got[$]; int wc; bit both;
    apply_reset();
    bus.cpu_request = 1'b1; bus.cpu_write = 1'b0; bus.cpu_address = 14'h0001;
    bus.dma_request = 1'b1; bus.dma_write = 1'b0; bus.dma_address = 14'h0002;
    both = 1'b0;
    for (int c = 0; c < 60 && got.size() < 10; c++) begin
      @(negedge clock);
      if (bus.cpu_ack && bus.dma_ack) both = 1'b1;
      if (bus.cpu_ack) got.push_back(0);
      if (bus.dma_ack) got.push_back(1);
    end
    bus.cpu_request = 1'b0; bus.dma_request = 1'b0;
    n_cmp++; if (both !== 1'b0) begin n_err++; $display("FAIL arb_dual_ack: got %b want 0", both); end
    n_cmp++; if (got.size() !== 10) begin n_err++; $display("FAIL arb_grant_count: got %0d want 10", got.size()); end
    wc = 0;
    for (int k = 0; k < got.size(); k++) begin
      int exp_own;
      exp_own = (wc == MAX_WAIT) ? 1 : 0;
      wc = exp_own ? 0 : wc + 1;
      n_cmp++;
      if (got[k] !== exp_own) begin n_err++; $display("FAIL arb_order[%0d]: got %0d want %0d", k, got[k], exp_own); end
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic test_drop();
    int bsy, cack, wes;
    mem[14'h0040] = 32'h0;
    @(negedge clock);
    bus.dma_request = 1'b1; bus.dma_write = 1'b0; bus.dma_address = 14'h0005;
    @(posedge clock); #1;
    n_cmp++; if ({bus.busy, bus.grant_dma} !== 2'b11) begin n_err++; $display("FAIL drop_dma_owner: got %b want 11", {bus.busy, bus.grant_dma}); end
    @(negedge clock);
    bus.cpu_request = 1'b1; bus.cpu_write = 1'b1; bus.cpu_address = 14'h0040; bus.cpu_data_in = 32'hCAFE0000;
    @(negedge clock);
    n_cmp++; if (bus.dma_ack !== 1'b1) begin n_err++; $display("FAIL drop_dma_ack: got %b want 1", bus.dma_ack); end
    bus.cpu_request = 1'b0; bus.dma_request = 1'b0;
    bsy = 0; cack = 0; wes = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      bsy += int'(bus.busy); cack += int'(bus.cpu_ack); wes += int'(bus.mem_write_enable);
    end
    n_cmp++; if (bsy !== 0) begin n_err++; $display("FAIL drop_busy: got %0d cycles want 0", bsy); end
    n_cmp++; if (cack !== 0) begin n_err++; $display("FAIL drop_cpu_ack: got %0d want 0", cack); end
    n_cmp++; if (wes !== 0 || mem[14'h0040] !== 32'h0) begin n_err++; $display("FAIL drop_no_write: got we=%0d mem=%h want 0/0", wes, mem[14'h0040]); end
  endtask

  task automatic test_reset_mid_issue();
    int acks, bsy, lat, wec, bc, oa; logic [DW-1:0] rd;
    mem[14'h0030] = 32'h0;
    @(negedge clock);
    bus.cpu_request = 1'b1; bus.cpu_write = 1'b1; bus.cpu_address = 14'h0030; bus.cpu_data_in = 32'hA5A5A5A5;
    @(posedge clock); #2;
    n_cmp++; if (bus.mem_write_enable !== 1'b1) begin n_err++; $display("FAIL mid_issue_we: got %b want 1", bus.mem_write_enable); end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({bus.busy, bus.grant_dma, bus.cpu_ack, bus.dma_ack, bus.mem_write_enable} !== 5'b0 ||
        {bus.mem_address, bus.mem_input_data, bus.cpu_data_out, bus.dma_data_out} !== '0) begin
      n_err++; $display("FAIL mid_reset_outputs: got busy=%b we=%b addr=%h din=%h want all 0",
                        bus.busy, bus.mem_write_enable, bus.mem_address, bus.mem_input_data);
    end
    bus.cpu_request = 1'b0;
    acks = 0; bsy = 0;
    repeat (2) begin @(negedge clock); acks += int'(bus.cpu_ack | bus.dma_ack); end
    reset = 1'b1;
    repeat (3) begin @(negedge clock); acks += int'(bus.cpu_ack | bus.dma_ack); bsy += int'(bus.busy); end
    n_cmp++; if (mem[14'h0030] !== 32'h0) begin n_err++; $display("FAIL mid_reset_mem: got %h want 0", mem[14'h0030]); end
    n_cmp++; if (acks !== 0) begin n_err++; $display("FAIL mid_reset_ack: got %0d want 0", acks); end
    n_cmp++; if (bsy !== 0) begin n_err++; $display("FAIL mid_reset_idle: got %0d busy cycles want 0", bsy); end
    run_txn(1'b0, 1'b0, 14'h0030, '0, lat, rd, wec, bc, oa);
    n_cmp++; if (lat !== 2 || rd !== 32'h0) begin n_err++; $display("FAIL mid_reset_resume: got lat=%0d data=%h want 2/0", lat, rd); end
  endtask

  task automatic test_random();
    logic [DW-1:0] mm [16];
    logic [DW-1:0] m_cdout, m_ddout, exp_rd;
    bit c_pend, d_pend, c_wr, d_wr, is_rd, dw;
    int c_idx, d_idx, owner, ack_cyc, free_at, wc, idx;
    logic [DW-1:0] c_dat, d_dat;
    bit exp_cack, exp_dack;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      mm[i] = $urandom;
      mem[256 + i] = mm[i];
    end
    m_cdout = '0; m_ddout = '0; exp_rd = '0;
    c_pend = 0; d_pend = 0; c_wr = 0; d_wr = 0; c_idx = 0; d_idx = 0; c_dat = '0; d_dat = '0;
    owner = 0; ack_cyc = -1; free_at = 0; wc = 0; is_rd = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clock);
      exp_cack = (cyc == ack_cyc) && (owner == 0);
      exp_dack = (cyc == ack_cyc) && (owner == 1);
      if (cyc == ack_cyc && is_rd) begin
        if (owner == 1) m_ddout = exp_rd; else m_cdout = exp_rd;
      end
      n_cmp++; if (bus.cpu_ack !== exp_cack) begin n_err++; $display("FAIL rand_cpu_ack@%0d: got %b want %b", cyc, bus.cpu_ack, exp_cack); end
      n_cmp++; if (bus.dma_ack !== exp_dack) begin n_err++; $display("FAIL rand_dma_ack@%0d: got %b want %b", cyc, bus.dma_ack, exp_dack); end
      n_cmp++; if (bus.cpu_data_out !== m_cdout) begin n_err++; $display("FAIL rand_cpu_dout@%0d: got %h want %h", cyc, bus.cpu_data_out, m_cdout); end
      n_cmp++; if (bus.dma_data_out !== m_ddout) begin n_err++; $display("FAIL rand_dma_dout@%0d: got %h want %h", cyc, bus.dma_data_out, m_ddout); end
      if (exp_cack) c_pend = 0;
      if (exp_dack) d_pend = 0;
      if (!c_pend && $urandom_range(0, 2) != 0) begin
        c_pend = 1; c_wr = 1'($urandom_range(0, 1)); c_idx = int'($urandom_range(0, 15)); c_dat = $urandom;
      end
      if (!d_pend && $urandom_range(0, 2) != 0) begin
        d_pend = 1; d_wr = 1'($urandom_range(0, 1)); d_idx = int'($urandom_range(0, 15)); d_dat = $urandom;
      end
      bus.cpu_request = c_pend; bus.cpu_write = c_wr; bus.cpu_address = 14'(256 + c_idx); bus.cpu_data_in = c_dat;
      bus.dma_request = d_pend; bus.dma_write = d_wr; bus.dma_address = 14'(256 + d_idx); bus.dma_data_in = d_dat;
      if (cyc >= free_at && (c_pend || d_pend)) begin
        dw = d_pend && (!c_pend || wc == MAX_WAIT);
        if (dw) wc = 0;
        else if (d_pend && wc < MAX_WAIT) wc++;
        owner = dw ? 1 : 0;
        idx   = dw ? d_idx : c_idx;
        is_rd = dw ? !d_wr : !c_wr;
        if (is_rd) exp_rd = mm[idx];
        else mm[idx] = dw ? d_dat : c_dat;
        ack_cyc = cyc + 2;
        free_at = cyc + 3;
      end
    end
    bus.cpu_request = 1'b0; bus.dma_request = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    clock = 1'b0; reset = 1'b0;
    bus.cpu_request = 1'b0; bus.cpu_write = 1'b0; bus.cpu_address = '0; bus.cpu_data_in = '0;
    bus.dma_request = 1'b0; bus.dma_write = 1'b0; bus.dma_address = '0; bus.dma_data_in = '0;
    bus.mem_output_data = '0;
    for (int i = 0; i < 16384; i++) mem[i] = '0;
    test_reset();
    test_cpu_read();
    test_cpu_write_read();
    test_dma_write_read();
    test_arbitration();
    test_drop();
    test_reset_mid_issue();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
